// File: rtl/cdb_pkg.sv
// Shared types and constants for the common-data-bus arbiter and its neighbours
// in the Tomasulo datapath.
package cdb_pkg;

    localparam int DATA_W      = 32;
    localparam int TAG_W       = 6;
    localparam int N_UNITS_MAX = 8;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  source;
        logic [DATA_W-1:0] data;
    } cdb_packet_t;

    // Opcode encoding shared with the adder so both sides decode identically
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b100,
        ALU_AND = 3'b101,
        ALU_NOT = 3'b110,
        ALU_XOR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Bundle of functional-unit request/result signals and the broadcast CDB packet.
// Statistics outputs exist only when CDB_STATS_EN is defined.
interface cdb_arbiter_if #(
    parameter int N_UNITS = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
);
    logic [N_UNITS-1:0]        unit_rts;
    logic [N_UNITS*DATA_W-1:0] unit_data;
    logic [N_UNITS*TAG_W-1:0]  unit_source;
    logic [N_UNITS-1:0]        unit_write;
    logic [N_UNITS-1:0]        unit_xmit;
    logic                      cdb_valid;
    logic [DATA_W-1:0]         cdb_data;
    logic [TAG_W-1:0]          cdb_source;
    logic                      cdb_error;
`ifdef CDB_STATS_EN
    logic [N_UNITS*16-1:0]     grant_count;
    logic [15:0]               conflict_cycles;
`endif

    modport master (
        input  unit_rts, unit_data, unit_source, unit_write,
        output unit_xmit, cdb_valid, cdb_data, cdb_source, cdb_error
`ifdef CDB_STATS_EN
        , output grant_count, conflict_cycles
`endif
    );

    modport slave (
        output unit_rts, unit_data, unit_source, unit_write,
        input  unit_xmit, cdb_valid, cdb_data, cdb_source, cdb_error
`ifdef CDB_STATS_EN
        , input grant_count, conflict_cycles
`endif
    );

endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping
// modulo N_UNITS.
module rr_picker #(
    parameter int N_UNITS = 4,
    parameter int PTR_W   = 2
) (
    input  logic [N_UNITS-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [N_UNITS-1:0] grant_onehot,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               any
);

    // Scan from the farthest offset down so the closest request to ptr wins last
    always_comb begin
        int j;
        grant_idx    = '0;
        grant_onehot = '0;
        any          = |req;
        j            = 0;
        for (int k = N_UNITS - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            if (j >= N_UNITS) begin
                j = j - N_UNITS;
            end
            if (req[j]) begin
                grant_idx = PTR_W'(j);
            end
        end
        if (any) begin
            grant_onehot[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one grant per cycle, registered broadcast of the
// granted unit's result. Define CDB_STATS_EN to add grant/conflict counters.
module cdb_arbiter #(
    parameter int N_UNITS = 4,
    parameter int DATA_W  = 32,
    parameter int TAG_W   = 6
) (
    input logic           clock,
    input logic           reset,
    cdb_arbiter_if.master bus
);
    import cdb_pkg::*;

    localparam int PTR_W = $clog2(N_UNITS);

    logic [N_UNITS-1:0] last_grant_q, last_grant_d;
    logic [N_UNITS-1:0] xmit_q, xmit_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   win_idx_q, win_idx_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [TAG_W-1:0]   source_q, source_d;
    logic               error_q, error_d;

    logic [N_UNITS-1:0] eligible;
    logic [N_UNITS-1:0] pick_onehot;
    logic [PTR_W-1:0]   pick_idx;
    logic               pick_any;

    // A unit granted last cycle still shows its stale rts, so mask it out
    assign eligible = bus.unit_rts & ~last_grant_q;

    rr_picker #(
        .N_UNITS (N_UNITS),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req          (eligible),
        .ptr          (rr_ptr_q),
        .grant_onehot (pick_onehot),
        .grant_idx    (pick_idx),
        .any          (pick_any)
    );

    always_comb begin
        xmit_d       = '0;
        last_grant_d = '0;
        rr_ptr_d     = rr_ptr_q;
        win_idx_d    = win_idx_q;
        if (pick_any) begin
            xmit_d       = pick_onehot;
            last_grant_d = pick_onehot;
            win_idx_d    = pick_idx;
            if (int'(pick_idx) == N_UNITS - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = pick_idx + 1'b1;
            end
        end
    end

    // Capture the unit granted in the cycle that is ending; a missing write is a protocol error
    always_comb begin
        valid_d  = 1'b0;
        data_d   = data_q;
        source_d = source_q;
        error_d  = error_q;
        if (|xmit_q) begin
            if (bus.unit_write[win_idx_q]) begin
                valid_d  = 1'b1;
                data_d   = bus.unit_data[int'(win_idx_q)*DATA_W +: DATA_W];
                source_d = bus.unit_source[int'(win_idx_q)*TAG_W +: TAG_W];
            end else begin
                error_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= '0;
            xmit_q       <= '0;
            rr_ptr_q     <= '0;
            win_idx_q    <= '0;
            valid_q      <= 1'b0;
            data_q       <= '0;
            source_q     <= '0;
            error_q      <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            xmit_q       <= xmit_d;
            rr_ptr_q     <= rr_ptr_d;
            win_idx_q    <= win_idx_d;
            valid_q      <= valid_d;
            data_q       <= data_d;
            source_q     <= source_d;
            error_q      <= error_d;
        end
    end

    assign bus.unit_xmit  = xmit_q;
    assign bus.cdb_valid  = valid_q;
    assign bus.cdb_data   = data_q;
    assign bus.cdb_source = source_q;
    assign bus.cdb_error  = error_q;

`ifdef CDB_STATS_EN
    logic [N_UNITS-1:0][15:0] grant_count_q, grant_count_d;
    logic [15:0]              conflict_q, conflict_d;

    always_comb begin
        grant_count_d = grant_count_q;
        conflict_d    = conflict_q;
        for (int i = 0; i < N_UNITS; i++) begin
            if (pick_onehot[i] && grant_count_q[i] != 16'hFFFF) begin
                grant_count_d[i] = grant_count_q[i] + 16'd1;
            end
        end
        if ($countones(eligible) >= 2 && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_count_q <= '0;
            conflict_q    <= '0;
        end else begin
            grant_count_q <= grant_count_d;
            conflict_q    <= conflict_d;
        end
    end

    assign bus.grant_count     = grant_count_q;
    assign bus.conflict_cycles = conflict_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter (4 units, 32-bit data, 6-bit tags).
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    cdb_packet_t exp_pkt;

    cdb_arbiter_if #(.N_UNITS(N), .DATA_W(32), .TAG_W(6)) bus ();

    cdb_arbiter #(.N_UNITS(N), .DATA_W(32), .TAG_W(6)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_unit(input int i, input logic [31:0] d, input logic [5:0] s, input logic w);
        bus.unit_data[i*32 +: 32] = d;
        bus.unit_source[i*6 +: 6] = s;
        bus.unit_write[i]         = w;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.unit_rts = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_xmit(input string name, input logic [N-1:0] exp);
        checks++;
        if (bus.unit_xmit !== exp) begin
            failures++;
            $display("[TB] FAIL %s: unit_xmit got %b expected %b", name, bus.unit_xmit, exp);
        end
    endtask

    task automatic check_pkt(input string name, input cdb_packet_t exp);
        checks++;
        if (bus.cdb_valid !== exp.valid || bus.cdb_data !== exp.data || bus.cdb_source !== exp.source) begin
            failures++;
            $display("[TB] FAIL %s: got v=%b d=%0d s=%0d expected v=%b d=%0d s=%0d", name,
                     bus.cdb_valid, bus.cdb_data, bus.cdb_source, exp.valid, exp.data, exp.source);
        end
    endtask

    task automatic check_err(input string name, input logic exp);
        checks++;
        if (bus.cdb_error !== exp) begin
            failures++;
            $display("[TB] FAIL %s: cdb_error got %b expected %b", name, bus.cdb_error, exp);
        end
    endtask

    task automatic test_reset();
        bus.unit_rts = '0;
        bus.unit_data = '0;
        bus.unit_source = '0;
        bus.unit_write = '0;
        reset = 1'b1;
        #2;
        check_xmit("reset_xmit", 4'b0000);
        exp_pkt = '{valid: 1'b0, source: 6'd0, data: 32'd0};
        check_pkt("reset_pkt", exp_pkt);
        check_err("reset_err", 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_unit(1, 32'd10, 6'd9, 1'b1);
        bus.unit_rts = 4'b0010;
        tick();
        check_xmit("single_grant", 4'b0010);
        bus.unit_rts = '0;
        tick();
        check_xmit("single_grant_pulse", 4'b0000);
        exp_pkt = '{valid: 1'b1, source: 6'd9, data: 32'd10};
        check_pkt("single_capture", exp_pkt);
        tick();
        exp_pkt = '{valid: 1'b0, source: 6'd9, data: 32'd10};
        check_pkt("single_idle_hold", exp_pkt);
    endtask

    task automatic test_contention();
        do_reset();
        for (int i = 0; i < N; i++) set_unit(i, 32'(100 + i), 6'(20 + i), 1'b1);
        bus.unit_rts = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            tick();
            check_xmit($sformatf("contend_grant%0d", c), 4'b0001 << (c % 4));
            if (c > 0) begin
                exp_pkt = '{valid: 1'b1, source: 6'(20 + (c - 1) % 4), data: 32'(100 + (c - 1) % 4)};
                check_pkt($sformatf("contend_pkt%0d", c), exp_pkt);
            end
        end
        bus.unit_rts = '0;
        tick();
        check_xmit("contend_end_xmit", 4'b0000);
        exp_pkt = '{valid: 1'b1, source: 6'd23, data: 32'd103};
        check_pkt("contend_last_pkt", exp_pkt);
`ifdef CDB_STATS_EN
        checks++;
        if (bus.conflict_cycles !== 16'd8) begin
            failures++;
            $display("[TB] FAIL contend_conflicts: got %0d expected 8", bus.conflict_cycles);
        end
`endif
    endtask

    task automatic test_held_single();
        do_reset();
        set_unit(2, 32'd42, 6'd2, 1'b1);
        bus.unit_rts = 4'b0100;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_xmit($sformatf("held_grant%0d", c), (c % 2 == 0) ? 4'b0100 : 4'b0000);
        end
        bus.unit_rts = '0;
        tick();
    endtask

    task automatic test_wrap();
        set_unit(0, 32'd500, 6'd30, 1'b1);
        set_unit(3, 32'd503, 6'd33, 1'b1);
        bus.unit_rts = 4'b1001;
        tick();
        check_xmit("wrap_first", 4'b1000);
        tick();
        check_xmit("wrap_second", 4'b0001);
        exp_pkt = '{valid: 1'b1, source: 6'd33, data: 32'd503};
        check_pkt("wrap_pkt3", exp_pkt);
        bus.unit_rts = '0;
        tick();
        exp_pkt = '{valid: 1'b1, source: 6'd30, data: 32'd500};
        check_pkt("wrap_pkt0", exp_pkt);
    endtask

    task automatic test_error();
        do_reset();
        bus.unit_write = '0;
        set_unit(1, 32'd77, 6'd3, 1'b1);
        set_unit(0, 32'd66, 6'd4, 1'b0);
        bus.unit_rts = 4'b0001;
        tick();
        check_xmit("err_grant", 4'b0001);
        bus.unit_rts = '0;
        tick();
        exp_pkt = '{valid: 1'b0, source: 6'd0, data: 32'd0};
        check_pkt("err_pkt", exp_pkt);
        check_err("err_set", 1'b1);
        tick();
        check_err("err_sticky", 1'b1);
        bus.unit_rts = 4'b0010;
        tick();
        check_xmit("err_next_grant", 4'b0010);
        bus.unit_rts = '0;
        tick();
        exp_pkt = '{valid: 1'b1, source: 6'd3, data: 32'd77};
        check_pkt("err_good_pkt", exp_pkt);
        check_err("err_still_sticky", 1'b1);
`ifdef CDB_STATS_EN
        checks++;
        if (bus.grant_count[15:0] !== 16'd1 || bus.grant_count[31:16] !== 16'd1) begin
            failures++;
            $display("[TB] FAIL err_grant_count: got %0d/%0d expected 1/1",
                     bus.grant_count[15:0], bus.grant_count[31:16]);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        check_err("midrst_err_cleared", 1'b0);
        set_unit(0, 32'd55, 6'd5, 1'b1);
        set_unit(3, 32'd58, 6'd8, 1'b1);
        bus.unit_rts = 4'b0001;
        tick();
        check_xmit("midrst_grant", 4'b0001);
        reset = 1'b1;
        #1;
        check_xmit("midrst_xmit_async", 4'b0000);
        exp_pkt = '{valid: 1'b0, source: 6'd0, data: 32'd0};
        check_pkt("midrst_pkt_async", exp_pkt);
        bus.unit_rts = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        tick();
        check_pkt("midrst_discarded", exp_pkt);
        bus.unit_rts = 4'b1001;
        tick();
        check_xmit("midrst_ptr_zero", 4'b0001);
        bus.unit_rts = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_contention();
        test_held_single();
        test_wrap();
        test_error();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
